// File: rtl/mux_nto1_scan_pkg.sv
`default_nettype none
// ============================================================================
// mux_nto1_scan_pkg : shared FSM encodings and mode constants for the scan mux
// Revision 1.0
// ============================================================================
package mux_nto1_scan_pkg;

  typedef enum logic [1:0] {
    S_MAN  = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mux_nto1_scan_if.sv
`default_nettype none
// ============================================================================
// mux_nto1_scan_if : channel bus, controls and tagged sample outputs of the mux
// Revision 1.0
// ============================================================================
interface mux_nto1_scan_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4
) ();
  localparam int SELW = $clog2(NCH);

  logic [NCH*WIDTH-1:0] in_bus;
  logic [SELW-1:0]      sel;
  logic                 mode;
  logic                 hold;
  logic [WIDTH-1:0]     out;
  logic [SELW-1:0]      out_ch;
  logic                 out_vld;
  logic                 ch_new;

  modport master (
    output in_bus, sel, mode, hold,
    input  out, out_ch, out_vld, ch_new
  );

  modport slave (
    input  in_bus, sel, mode, hold,
    output out, out_ch, out_vld, ch_new
  );
endinterface
`default_nettype wire

// File: rtl/mux_dwell_cnt.sv
`default_nettype none
// ============================================================================
// mux_dwell_cnt : dwell counter, flags the last cycle spent on a scan channel
// Revision 1.0
// ============================================================================
module mux_dwell_cnt #(
  parameter int DWELL = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic wrap
);
  localparam int CW = $clog2(DWELL + 1);

  logic [CW-1:0] r_cnt;

  assign wrap = (32'(r_cnt) == DWELL - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= wrap ? '0 : r_cnt + CW'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/mux_nto1_scan.sv
`default_nettype none
// ============================================================================
// mux_nto1_scan : registered N-to-1 mux with manual select and round-robin scan
// Revision 1.0
// ============================================================================
module mux_nto1_scan
  import mux_nto1_scan_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int DWELL = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_nto1_scan_if.slave        bus
);
  localparam int SELW = $clog2(NCH);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_ret;
  logic [SELW-1:0]  r_ptr;
  logic [SELW-1:0]  w_ptr_next;
  logic [WIDTH-1:0] r_out;
  logic [SELW-1:0]  r_out_ch;
  logic             r_out_vld;
  logic             r_ch_new;
  logic             w_wrap;
  logic             w_sel_ok;
  logic             w_step;
  logic             w_entry;
  logic             w_man;
  logic             w_load;
  logic [WIDTH-1:0] w_data;

  assign w_sel_ok = (32'(bus.sel) < NCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_MAN;
    else        r_state <= w_state_next;
  end

  // A held scan resumes its dwell count only if it was scanning when frozen;
  // otherwise leaving hold into scan starts a fresh dwell on the current ptr.
  always_comb begin
    w_state_next = r_state;
    w_step       = 1'b0;
    w_entry      = 1'b0;
    w_man        = 1'b0;
    if (bus.hold) begin
      w_state_next = S_HOLD;
    end else if (bus.mode == MODE_SCAN) begin
      w_state_next = S_SCAN;
      if (r_state == S_SCAN || (r_state == S_HOLD && r_ret == MODE_SCAN))
        w_step = 1'b1;
      else
        w_entry = 1'b1;
    end else begin
      w_state_next = S_MAN;
      w_man        = 1'b1;
    end
  end

  always_comb begin
    w_ptr_next = r_ptr;
    if (w_step && w_wrap)
      w_ptr_next = (32'(r_ptr) == NCH - 1) ? '0 : r_ptr + SELW'(1);
    else if (w_man && w_sel_ok)
      w_ptr_next = bus.sel;
  end

  assign w_load = w_step || w_entry || (w_man && w_sel_ok);
  assign w_data = bus.in_bus[int'(w_ptr_next)*WIDTH +: WIDTH];

  mux_dwell_cnt #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_step),
    .clr   (w_entry || w_man),
    .wrap  (w_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_ret <= MODE_MAN;
    end else begin
      r_ptr <= w_ptr_next;
      if (bus.hold && r_state != S_HOLD)
        r_ret <= bus.mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_out_ch  <= '0;
      r_out_vld <= 1'b0;
      r_ch_new  <= 1'b0;
    end else if (w_load) begin
      r_out     <= w_data;
      r_out_ch  <= w_ptr_next;
      r_out_vld <= 1'b1;
      r_ch_new  <= (w_ptr_next != r_out_ch);
    end else begin
      r_ch_new <= 1'b0;
      if (w_man)
        r_out_vld <= 1'b0;
    end
  end

  assign bus.out     = r_out;
  assign bus.out_ch  = r_out_ch;
  assign bus.out_vld = r_out_vld;
  assign bus.ch_new  = r_ch_new;
endmodule
`default_nettype wire

// File: tb/tb_mux_nto1_scan.sv
`default_nettype none
// ============================================================================
// tb_mux_nto1_scan : scoreboard bench for a 4-channel/DWELL=3 and a 3-channel/DWELL=1 build
// Revision 1.0
// ============================================================================
module tb_mux_nto1_scan;

  typedef struct packed {
    logic [3:0] out;
    logic [1:0] ch;
    logic       vld;
    logic       chn;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  exp_t q4[$];
  exp_t q3[$];

  bit          cur_mode, cur_hold;
  int          cur_sel;
  logic [15:0] cur_bus;

  // reference state per build: 0 = NCH 4 / DWELL 3, 1 = NCH 3 / DWELL 1
  int m_ptr[2], m_k[2], m_och[2], m_out[2];
  bit m_vld[2], m_chn[2], m_scan[2], m_held[2], m_ret[2];

  mux_nto1_scan_if #(.WIDTH(4), .NCH(4)) bus4 ();
  mux_nto1_scan_if #(.WIDTH(4), .NCH(3)) bus3 ();

  mux_nto1_scan #(.WIDTH(4), .NCH(4), .DWELL(3)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  mux_nto1_scan #(.WIDTH(4), .NCH(3), .DWELL(1)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_k[d] = 1; m_och[d] = 0; m_out[d] = 0;
      m_vld[d] = 0; m_chn[d] = 0; m_scan[d] = 0; m_held[d] = 0; m_ret[d] = 0;
    end
  endtask

  task automatic emit(input int d, input logic [15:0] b);
    m_chn[d] = (m_ptr[d] != m_och[d]);
    m_och[d] = m_ptr[d];
    m_out[d] = int'((b >> (4 * m_ptr[d])) & 16'hF);
    m_vld[d] = 1'b1;
  endtask

  // One clock edge of the behavioural model; k counts samples taken on ptr.
  task automatic model_step(input int d, input bit md, input bit hd, input int s, input logic [15:0] b);
    int   nch;
    int   dw;
    bit   go;
    exp_t e;
    nch = (d == 0) ? 4 : 3;
    dw  = (d == 0) ? 3 : 1;
    if (hd) begin
      if (!m_held[d]) begin
        m_held[d] = 1'b1;
        m_ret[d]  = md;
      end
      m_chn[d] = 1'b0;
    end else begin
      go        = md && (m_held[d] ? m_ret[d] : m_scan[d]);
      m_held[d] = 1'b0;
      m_scan[d] = md;
      if (!md) begin
        m_k[d] = 1;
        if (s < nch) begin
          m_ptr[d] = s;
          emit(d, b);
        end else begin
          m_vld[d] = 1'b0;
          m_chn[d] = 1'b0;
        end
      end else begin
        if (go) begin
          if (m_k[d] == dw) begin
            m_ptr[d] = (m_ptr[d] + 1) % nch;
            m_k[d]   = 1;
          end else begin
            m_k[d] = m_k[d] + 1;
          end
        end else begin
          m_k[d] = 1;
        end
        emit(d, b);
      end
    end
    e.out = 4'(m_out[d]);
    e.ch  = 2'(m_och[d]);
    e.vld = m_vld[d];
    e.chn = m_chn[d];
    if (d == 0) q4.push_back(e);
    else        q3.push_back(e);
  endtask

  task automatic drive(input bit md, input bit hd, input int s, input logic [15:0] b);
    cur_mode = md; cur_hold = hd; cur_sel = s; cur_bus = b;
    bus4.mode = md; bus4.hold = hd; bus4.sel = 2'(s); bus4.in_bus = b;
    bus3.mode = md; bus3.hold = hd; bus3.sel = 2'(s); bus3.in_bus = b[11:0];
    if (rst_n) begin
      model_step(0, md, hd, s, b);
      model_step(1, md, hd, s, b);
    end
  endtask

  task automatic step(input bit md, input bit hd, input int s, input logic [15:0] b);
    @(negedge clk);
    drive(md, hd, s, b);
  endtask

  function automatic exp_t actual(input int d);
    exp_t a;
    if (d == 0) a = {bus4.out, bus4.out_ch, bus4.out_vld, bus4.ch_new};
    else        a = {bus3.out, bus3.out_ch, bus3.out_vld, bus3.ch_new};
    return a;
  endfunction

  task automatic compare(input string name, input exp_t a, input exp_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s @%0t: got out=%h ch=%0d vld=%b new=%b, want out=%h ch=%0d vld=%b new=%b",
               name, $time, a.out, a.ch, a.vld, a.chn, e.out, e.ch, e.vld, e.chn);
    end
  endtask

  // Reset is applied between edges and must clear the outputs without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    compare("reset_dut4", actual(0), '0);
    compare("reset_dut3", actual(1), '0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(cur_mode, cur_hold, cur_sel, cur_bus);
  endtask

  // The DUT presents a sample every cycle; each queued expectation is retired one edge after it was issued.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q4.size() > 0) compare("sample_dut4", actual(0), q4.pop_front());
      if (q3.size() > 0) compare("sample_dut3", actual(1), q3.pop_front());
    end
  end

  initial begin
    rst_n = 1'b1;
    cur_mode = 1'b0; cur_hold = 1'b0; cur_sel = 0; cur_bus = 16'hA5C3;
    bus4.mode = 1'b0; bus4.hold = 1'b0; bus4.sel = '0; bus4.in_bus = '0;
    bus3.mode = 1'b0; bus3.hold = 1'b0; bus3.sel = '0; bus3.in_bus = '0;
    #2;
    do_reset();

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, i, 16'hA5C3);

    step(1'b0, 1'b0, 0, 16'hA5C3);
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 0, 16'hA5C3);

    step(1'b1, 1'b0, 0, 16'h1234);
    step(1'b1, 1'b0, 0, 16'h1234);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 0, 16'($urandom));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 16'h9876);

    step(1'b0, 1'b1, 2, 16'hBEEF);
    step(1'b0, 1'b1, 2, 16'h0F0F);
    step(1'b0, 1'b0, 2, 16'hCAFE);

    step(1'b0, 1'b0, 3, 16'h4321);
    step(1'b0, 1'b0, 3, 16'h5555);
    step(1'b0, 1'b0, 1, 16'h6789);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0, 16'h3C3C);
    @(posedge clk);
    #3;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, 16'hD2E1);

    for (int i = 0; i < 400; i++) begin
      bit md;
      md = ($urandom_range(7) == 0) ? !cur_mode : cur_mode;
      step(md, ($urandom_range(4) == 0), int'($urandom_range(3)), 16'($urandom));
      if (i == 200) begin
        @(posedge clk);
        #3;
        do_reset();
      end
    end

    repeat (3) @(negedge clk);
    total++;
    if (q4.size() != 0 || q3.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d pending samples, want 0/0", q4.size(), q3.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
